// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad entry buffer.
// Command codes are only decoded when KEYPAD_CMD_EN is defined.
package keypad_pkg;

   localparam logic [3:0] KEY_CLEAR  = 4'hC;
   localparam logic [3:0] KEY_BACK   = 4'hE;
   localparam logic [3:0] KEY_ENTER  = 4'hF;

   localparam int         NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      RELEASE_DB
   } db_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Press/release debouncer. key_strobe is a combinational "accept on this
// edge" qualifier; the parent registers it, so the registered strobe and
// the key capture land on the same clock edge.
module key_debouncer
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic key_pressed,
   output logic key_strobe
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
   // Counter is cleared on the first sampled edge, so the final stable
   // sample of the window is seen while the counter holds DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0]   CNT_END = CW'(DEBOUNCE_CYCLES - 1);

   db_state_t       r_state;
   db_state_t       w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;

   // State and counter registers.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state, counter and accept decode.
   // NOTE: every output of this block is given a default first, so no
   // path through the case can leave a signal unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      key_strobe   = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_pressed) begin
               w_state_next = PRESS_DB;
               w_cnt_next   = '0;
            end
         end
         PRESS_DB: begin
            if (!key_pressed) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt == CNT_END) begin
               w_state_next = HELD;
               w_cnt_next   = '0;
               key_strobe   = 1'b1;
            end else begin
               w_cnt_next   = r_cnt + CW'(1);
            end
         end
         HELD: begin
            if (!key_pressed) begin
               w_state_next = RELEASE_DB;
               w_cnt_next   = '0;
            end
         end
         RELEASE_DB: begin
            if (key_pressed) begin
               // Release bounce: back to HELD without a new strobe.
               w_state_next = HELD;
               w_cnt_next   = '0;
            end else if (r_cnt == CNT_END) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: debounced single strobe per press, key capture and
// a 4-digit hex entry register. Define KEYPAD_CMD_EN to enable the
// C (clear), E (backspace) and F (enter/commit) command keys.
module keypad_entry_buffer
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_code,
   input  logic        key_pressed,
   output logic        key_strobe,
   output logic [3:0]  last_key,
   output logic [15:0] digits,
   output logic [2:0]  digit_cnt,
   output logic        entry_full,
   output logic        entry_valid,
   output logic [15:0] entry_value
);

   localparam logic [2:0] CNT_FULL = 3'(NUM_DIGITS);

   logic        w_accept;
   logic        r_key_strobe;
   logic [3:0]  r_last_key;
   logic [15:0] r_digits;
   logic [15:0] w_digits_next;
   logic [2:0]  r_digit_cnt;
   logic [2:0]  w_cnt_next;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_pressed (key_pressed),
      .key_strobe  (w_accept)
   );

`ifdef KEYPAD_CMD_EN
   logic        w_commit;
   logic        r_entry_valid;
   logic [15:0] r_entry_value;

   // Key action with command decode: C clears, E backspaces, F commits.
   always_comb begin
      w_digits_next = r_digits;
      w_cnt_next    = r_digit_cnt;
      w_commit      = 1'b0;
      case (key_code)
         KEY_CLEAR: begin
            w_digits_next = '0;
            w_cnt_next    = '0;
         end
         KEY_BACK: begin
            if (r_digit_cnt != 3'd0) begin
               w_digits_next = r_digits >> 4;
               w_cnt_next    = r_digit_cnt - 3'd1;
            end
         end
         KEY_ENTER: begin
            w_commit      = 1'b1;
            w_digits_next = '0;
            w_cnt_next    = '0;
         end
         default: begin
            w_digits_next = {r_digits[11:0], key_code};
            w_cnt_next    = (r_digit_cnt == CNT_FULL) ? CNT_FULL : r_digit_cnt + 3'd1;
         end
      endcase
   end

   // Commit register: value held until the next enter key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry_valid <= 1'b0;
         r_entry_value <= '0;
      end else begin
         r_entry_valid <= w_accept & w_commit;
         if (w_accept && w_commit) begin
            r_entry_value <= r_digits;
         end
      end
   end

   assign entry_valid = r_entry_valid;
   assign entry_value = r_entry_value;
`else
   // Key action: every code is a digit shifted in at the newest position.
   always_comb begin
      w_digits_next = {r_digits[11:0], key_code};
      w_cnt_next    = (r_digit_cnt == CNT_FULL) ? CNT_FULL : r_digit_cnt + 3'd1;
   end

   assign entry_valid = 1'b0;
   assign entry_value = '0;
`endif

   // Strobe, capture and entry registers; key_code is sampled only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_strobe <= 1'b0;
         r_last_key   <= '0;
         r_digits     <= '0;
         r_digit_cnt  <= '0;
      end else begin
         r_key_strobe <= w_accept;
         if (w_accept) begin
            r_last_key  <= key_code;
            r_digits    <= w_digits_next;
            r_digit_cnt <= w_cnt_next;
         end
      end
   end

   assign key_strobe = r_key_strobe;
   assign last_key   = r_last_key;
   assign digits     = r_digits;
   assign digit_cnt  = r_digit_cnt;
   assign entry_full = (r_digit_cnt == CNT_FULL);

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench for keypad_entry_buffer. Stimulus pushes the expected
// strobe (cycle and register contents) from a queue-based entry model; a
// negedge monitor pops and compares whenever the DUT strobes.
module tb_keypad_entry_buffer;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        key_pressed = 1'b0;
   logic        key_strobe;
   logic [3:0]  last_key;
   logic [15:0] digits;
   logic [2:0]  digit_cnt;
   logic        entry_full;
   logic        entry_valid;
   logic [15:0] entry_value;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  key;
      logic [15:0] digits;
      logic [2:0]  cnt;
      logic        full;
      logic        valid;
      logic [15:0] value;
   } exp_t;

   exp_t        sb_q[$];
   int          md[$];          // entered digits, oldest first
   logic [15:0] m_value = '0;

   keypad_entry_buffer #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_code    (key_code),
      .key_pressed (key_pressed),
      .key_strobe  (key_strobe),
      .last_key    (last_key),
      .digits      (digits),
      .digit_cnt   (digit_cnt),
      .entry_full  (entry_full),
      .entry_valid (entry_valid),
      .entry_value (entry_value)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack_digits();
      logic [15:0] v;
      v = '0;
      foreach (md[i]) v = (v << 4) | 16'(md[i]);
      return v;
   endfunction

   // Entry model: apply one accepted key and queue the expected strobe.
   task automatic model_accept(input logic [3:0] code, input int when);
      exp_t e;
      logic valid;
      valid = 1'b0;
`ifdef KEYPAD_CMD_EN
      if (code == 4'hC) md.delete();
      else if (code == 4'hE) begin
         if (md.size() > 0) void'(md.pop_back());
      end else if (code == 4'hF) begin
         m_value = pack_digits();
         valid   = 1'b1;
         md.delete();
      end else
`endif
      begin
         md.push_back(int'(code));
         if (md.size() > 4) void'(md.pop_front());
      end
      e.cyc    = when;
      e.key    = code;
      e.digits = pack_digits();
      e.cnt    = 3'(md.size());
      e.full   = (md.size() == 4);
      e.valid  = valid;
`ifdef KEYPAD_CMD_EN
      e.value  = m_value;
`else
      e.value  = 16'h0;
`endif
      sb_q.push_back(e);
   endtask

   // One key activity: 'hold' edges high, optional release bounce, then 'low' edges low.
   task automatic press(input logic [3:0] code, input int hold, input int low, input int bounce);
      @(posedge clk); #1;
      key_code    = code;
      key_pressed = 1'b1;
      if (hold >= D + 1) model_accept(code, cyc + 1 + D);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (i >= D) key_code = 4'($urandom_range(0, 15));  // must be ignored once held
      end
      key_pressed = 1'b0;
      if (bounce > 0) begin
         repeat (bounce) @(posedge clk);
         #1 key_pressed = 1'b1;
         repeat (2) @(posedge clk);
         #1 key_pressed = 1'b0;
      end
      repeat (low) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every strobe against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (key_strobe) begin
            if (sb_q.size() == 0) begin
               check("unexpected_strobe", 32'(key_strobe), 32'h0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("strobe_cycle", 32'(cyc), 32'(e.cyc));
               check("last_key",     32'(last_key),    32'(e.key));
               check("digits",       32'(digits),      32'(e.digits));
               check("digit_cnt",    32'(digit_cnt),   32'(e.cnt));
               check("entry_full",   32'(entry_full),  32'(e.full));
               check("entry_valid",  32'(entry_valid), 32'(e.valid));
               check("entry_value",  32'(entry_value), 32'(e.value));
            end
         end else if (entry_valid) begin
            check("entry_valid_without_strobe", 32'(entry_valid), 32'h0);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_key_strobe"},  32'(key_strobe),  32'h0);
      check({tag, "_last_key"},    32'(last_key),    32'h0);
      check({tag, "_digits"},      32'(digits),      32'h0);
      check({tag, "_digit_cnt"},   32'(digit_cnt),   32'h0);
      check({tag, "_entry_full"},  32'(entry_full),  32'h0);
      check({tag, "_entry_valid"}, 32'(entry_valid), 32'h0);
      check({tag, "_entry_value"}, 32'(entry_value), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] snap_digits;
      logic [3:0]  snap_key;

      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      rst_n = 1'b1;

      // Single key 5 held for 20 cycles.
      press(4'h5, 20, D + 2, 0);
      check("k5_last_key",  32'(last_key),  32'h5);
      check("k5_digits",    32'(digits),    32'h0005);
      check("k5_digit_cnt", 32'(digit_cnt), 32'h1);

      // Press glitches: 3 high, 2 low, five times -> nothing accepted.
      snap_digits = digits;
      snap_key    = last_key;
      for (int i = 0; i < 5; i++) press(4'hA, 3, 2, 0);
      repeat (D + 2) @(posedge clk);
      #1;
      check("glitch_digits",   32'(digits),   32'(snap_digits));
      check("glitch_last_key", 32'(last_key), 32'(snap_key));

      // Fill past capacity: oldest digits shift out.
      press(4'h1, D + 3, D + 2, 0);
      press(4'h2, D + 3, D + 2, 0);
      press(4'h3, D + 3, D + 2, 0);
      press(4'h4, D + 3, D + 2, 3);
      press(4'h7, D + 3, D + 2, 0);
      check("full_digits",     32'(digits),     32'h2347);
      check("full_digit_cnt",  32'(digit_cnt),  32'h4);
      check("full_entry_full", 32'(entry_full), 32'h1);

`ifdef KEYPAD_CMD_EN
      press(4'hC, D + 2, D + 2, 0);
      press(4'h1, D + 2, D + 2, 0);
      press(4'h2, D + 2, D + 2, 0);
      press(4'hE, D + 2, D + 2, 0);
      check("back_digits",    32'(digits),    32'h0001);
      check("back_digit_cnt", 32'(digit_cnt), 32'h1);
      press(4'h9, D + 2, D + 2, 0);
      press(4'hF, D + 2, D + 2, 0);
      check("enter_value",     32'(entry_value), 32'h0019);
      check("enter_digits",    32'(digits),      32'h0000);
      check("enter_digit_cnt", 32'(digit_cnt),   32'h0);
      press(4'hE, D + 2, D + 2, 0);   // backspace at zero
      press(4'hF, D + 2, D + 2, 0);   // empty commit
      check("empty_enter_value", 32'(entry_value), 32'h0000);
`else
      press(4'hC, D + 2, D + 2, 0);
      check("c_digit_digits",  32'(digits),      32'h347C);
      check("c_digit_valid",   32'(entry_valid), 32'h0);
`endif

      // Randomized presses and glitches.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            press(4'($urandom_range(0, 15)), $urandom_range(1, D), $urandom_range(1, 3), 0);
         else
            press(4'($urandom_range(0, 15)), $urandom_range(D + 1, D + 12),
                  $urandom_range(D + 1, D + 4),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, D) : 0);
      end
      repeat (D + 2) @(posedge clk);

      // Make sure there is state to clear, then reset mid-debounce at edge 5.
      press(4'h6, D + 2, D + 2, 0);
      @(posedge clk); #1;
      key_code    = 4'h9;
      key_pressed = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      md.delete();
      m_value = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_accept(4'h9, cyc + 1 + D);
      repeat (D + 4) @(posedge clk);
      #1 key_pressed = 1'b0;
      repeat (D + 3) @(posedge clk);
      #1;
      check("post_reset_digits", 32'(digits), 32'h0009);

      repeat (5) @(posedge clk);
      #1 check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
